// File: rtl/regfile_2w2r_param.sv
// Register file with two write ports, two registered read ports and zeroing after reset.
// Optional write-to-read bypass when REGFILE_BYPASS_EN is defined.
module regfile_2w2r_param #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              write1,
    input  logic [ADDR_W-1:0] write_index1,
    input  logic [WIDTH-1:0]  write_data1,
    input  logic              write2,
    input  logic [ADDR_W-1:0] write_index2,
    input  logic [WIDTH-1:0]  write_data2,
    input  logic [ADDR_W-1:0] read_index1,
    input  logic [ADDR_W-1:0] read_index2,
    output logic [WIDTH-1:0]  read_value1,
    output logic [WIDTH-1:0]  read_value2,
    output logic              ready,
    output logic              collision
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] init_cnt;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  rd1;
    logic [WIDTH-1:0]  rd2;
    logic              do_w1;
    logic              do_w2;
    logic              same_index;

    always_comb begin
        do_w1      = write1 && !(ZERO_REG != 0 && write_index1 == '0);
        do_w2      = write2 && !(ZERO_REG != 0 && write_index2 == '0);
        same_index = write1 && write2 && (write_index1 == write_index2);
    end

    // Port 1 is applied last in the bypass chain so it wins a dual-port match.
    always_comb begin
        rd1 = mem[read_index1];
        rd2 = mem[read_index2];
`ifdef REGFILE_BYPASS_EN
        if (write2 && write_index2 == read_index1) rd1 = write_data2;
        if (write1 && write_index1 == read_index1) rd1 = write_data1;
        if (write2 && write_index2 == read_index2) rd2 = write_data2;
        if (write1 && write_index1 == read_index2) rd2 = write_data1;
`endif
        if (ZERO_REG != 0 && read_index1 == '0) rd1 = '0;
        if (ZERO_REG != 0 && read_index2 == '0) rd2 = '0;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= INIT;
            init_cnt    <= '0;
            ready       <= 1'b0;
            collision   <= 1'b0;
            read_value1 <= '0;
            read_value2 <= '0;
        end else begin
            case (state)
                INIT: begin
                    mem[init_cnt] <= '0;
                    init_cnt      <= init_cnt + 1'b1;
                    ready         <= 1'b0;
                    collision     <= 1'b0;
                    read_value1   <= '0;
                    read_value2   <= '0;
                    if (init_cnt == '1) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    // Port 2 first so a same-index port 1 write overrides it.
                    if (do_w2) mem[write_index2] <= write_data2;
                    if (do_w1) mem[write_index1] <= write_data1;
                    read_value1 <= rd1;
                    read_value2 <= rd2;
                    collision   <= same_index;
                    ready       <= 1'b1;
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_2w2r_param.sv
// Bench for regfile_2w2r_param: two instances (ZERO_REG=0 and 1) fed identical stimulus,
// checked against an array-based reference model.
module tb_regfile_2w2r_param;

    localparam int DEPTH = 32;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        write1 = 1'b0, write2 = 1'b0;
    logic [4:0]  write_index1 = '0, write_index2 = '0;
    logic [31:0] write_data1 = '0, write_data2 = '0;
    logic [4:0]  read_index1 = '0, read_index2 = '0;

    logic [31:0] a_rv1, a_rv2, z_rv1, z_rv2;
    logic        a_ready, z_ready, a_col, z_col;

    int checks = 0;
    int passed = 0;

    // Reference model state
    logic [31:0] m_a [DEPTH];
    logic [31:0] m_z [DEPTH];
    int          init_left = DEPTH;
    logic [31:0] e_a1 = '0, e_a2 = '0, e_z1 = '0, e_z2 = '0;
    logic        e_ready = 1'b0, e_col = 1'b0;

    always #5 clock = ~clock;

    regfile_2w2r_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(0)) dut_a (
        .clock(clock), .clear(clear),
        .write1(write1), .write_index1(write_index1), .write_data1(write_data1),
        .write2(write2), .write_index2(write_index2), .write_data2(write_data2),
        .read_index1(read_index1), .read_index2(read_index2),
        .read_value1(a_rv1), .read_value2(a_rv2),
        .ready(a_ready), .collision(a_col)
    );

    regfile_2w2r_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1)) dut_z (
        .clock(clock), .clear(clear),
        .write1(write1), .write_index1(write_index1), .write_data1(write_data1),
        .write2(write2), .write_index2(write_index2), .write_data2(write_data2),
        .read_index1(read_index1), .read_index2(read_index2),
        .read_value1(z_rv1), .read_value2(z_rv2),
        .ready(z_ready), .collision(z_col)
    );

    function automatic logic [31:0] mread(input bit z, input logic [4:0] ri);
        logic [31:0] v;
        v = z ? m_z[ri] : m_a[ri];
`ifdef REGFILE_BYPASS_EN
        if (write1 && write_index1 == ri)      v = write_data1;
        else if (write2 && write_index2 == ri) v = write_data2;
`endif
        if (z && ri == 5'd0) v = '0;
        return v;
    endfunction

    // Advance the model by one clock edge using the current inputs, then let the DUT take the edge.
    task automatic tick();
        if (clear) begin
            init_left = DEPTH;
            e_ready = 1'b0; e_col = 1'b0;
            e_a1 = '0; e_a2 = '0; e_z1 = '0; e_z2 = '0;
        end else if (init_left > 0) begin
            m_a[DEPTH - init_left] = '0;
            m_z[DEPTH - init_left] = '0;
            init_left--;
            e_ready = (init_left == 0);
            e_col = 1'b0;
            e_a1 = '0; e_a2 = '0; e_z1 = '0; e_z2 = '0;
        end else begin
            e_a1 = mread(1'b0, read_index1);
            e_a2 = mread(1'b0, read_index2);
            e_z1 = mread(1'b1, read_index1);
            e_z2 = mread(1'b1, read_index2);
            e_col = write1 && write2 && (write_index1 == write_index2);
            e_ready = 1'b1;
            if (write2) begin
                m_a[write_index2] = write_data2;
                if (write_index2 != 5'd0) m_z[write_index2] = write_data2;
            end
            if (write1) begin
                m_a[write_index1] = write_data1;
                if (write_index1 != 5'd0) m_z[write_index1] = write_data1;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        write1 = 1'b0;
        write2 = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        clear = 1'b1;
        tick();
        checks++; if (a_ready !== 1'b0 || z_ready !== 1'b0)
            $display("FAIL reset_ready_low got a=%b z=%b exp=0", a_ready, z_ready); else passed++;
        clear = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            write1 = 1'b1; write_index1 = 5'(i); write_data1 = 32'hDEAD0000 + 32'(i);
            read_index1 = 5'(i); read_index2 = 5'(i);
            tick();
            checks++; if (a_ready !== (i == DEPTH) || z_ready !== (i == DEPTH))
                $display("FAIL reset_ready cyc=%0d got a=%b z=%b exp=%b", i, a_ready, z_ready, (i == DEPTH)); else passed++;
            checks++; if (a_rv1 !== 32'd0 || a_rv2 !== 32'd0 || a_col !== 1'b0)
                $display("FAIL reset_init_outputs cyc=%0d got rv1=%h rv2=%h col=%b exp=0", i, a_rv1, a_rv2, a_col); else passed++;
        end
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            read_index1 = 5'(i); read_index2 = 5'(DEPTH - 1 - i);
            tick();
            checks++; if (a_rv1 !== 32'd0 || a_rv2 !== 32'd0 || z_rv1 !== 32'd0 || z_rv2 !== 32'd0)
                $display("FAIL reset_zeroed idx=%0d got %h %h %h %h exp=0", i, a_rv1, a_rv2, z_rv1, z_rv2); else passed++;
        end
    endtask

    task automatic test_dual_write();
        write1 = 1'b1; write_index1 = 5'd0; write_data1 = 32'd1081;
        write2 = 1'b1; write_index2 = 5'd1; write_data2 = 32'd2553;
        read_index1 = 5'd20; read_index2 = 5'd21;
        tick();
        checks++; if (a_col !== 1'b0 || z_col !== 1'b0)
            $display("FAIL dual_collision got a=%b z=%b exp=0", a_col, z_col); else passed++;
        idle();
        read_index1 = 5'd0; read_index2 = 5'd1;
        tick();
        checks++; if (a_rv1 !== 32'd1081 || a_rv2 !== 32'd2553)
            $display("FAIL dual_read got %0d %0d exp 1081 2553", a_rv1, a_rv2); else passed++;
        checks++; if (z_rv1 !== 32'd0 || z_rv2 !== 32'd2553)
            $display("FAIL dual_read_zreg got %0d %0d exp 0 2553", z_rv1, z_rv2); else passed++;
    endtask

    task automatic test_collision();
        write1 = 1'b1; write_index1 = 5'd2; write_data1 = 32'd10283;
        write2 = 1'b1; write_index2 = 5'd2; write_data2 = 32'd66;
        tick();
        checks++; if (a_col !== 1'b1 || z_col !== 1'b1)
            $display("FAIL collision_pulse got a=%b z=%b exp=1", a_col, z_col); else passed++;
        idle();
        read_index1 = 5'd2;
        tick();
        checks++; if (a_col !== 1'b0 || z_col !== 1'b0)
            $display("FAIL collision_one_cycle got a=%b z=%b exp=0", a_col, z_col); else passed++;
        checks++; if (a_rv1 !== 32'd10283 || z_rv1 !== 32'd10283)
            $display("FAIL collision_winner got a=%0d z=%0d exp=10283", a_rv1, z_rv1); else passed++;
    endtask

    task automatic test_bypass();
        logic [31:0] exp_first;
`ifdef REGFILE_BYPASS_EN
        exp_first = 32'd54210;
`else
        exp_first = 32'd0;
`endif
        write1 = 1'b1; write_index1 = 5'd13; write_data1 = 32'd54210;
        read_index1 = 5'd13;
        tick();
        checks++; if (a_rv1 !== exp_first || z_rv1 !== exp_first)
            $display("FAIL bypass_same_cycle got a=%0d z=%0d exp=%0d", a_rv1, z_rv1, exp_first); else passed++;
        idle();
        tick();
        checks++; if (a_rv1 !== 32'd54210)
            $display("FAIL bypass_next_read got %0d exp=54210", a_rv1); else passed++;
    endtask

    task automatic test_mid_clear();
        write1 = 1'b1; write_index1 = 5'd5; write_data1 = 32'd7;
        tick();
        idle();
        read_index1 = 5'd5;
        tick();
        checks++; if (a_rv1 !== 32'd7)
            $display("FAIL midclear_pre got %0d exp=7", a_rv1); else passed++;
        write1 = 1'b1; write_data1 = 32'd8;
        clear = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (a_ready !== 1'b0 || a_rv1 !== 32'd0 || a_col !== 1'b0)
                $display("FAIL midclear_held cyc=%0d got rdy=%b rv1=%0d col=%b exp 0 0 0", i, a_ready, a_rv1, a_col); else passed++;
        end
        clear = 1'b0;
        write1 = 1'b1; write_data1 = 32'd9;
        write2 = 1'b1; write_index2 = 5'd5; write_data2 = 32'd9;
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            checks++; if (a_ready !== (i == DEPTH) || a_col !== 1'b0 || z_col !== 1'b0)
                $display("FAIL midclear_init cyc=%0d got rdy=%b col=%b/%b exp rdy=%b col=0", i, a_ready, a_col, z_col, (i == DEPTH)); else passed++;
        end
        idle();
        tick();
        checks++; if (a_rv1 !== 32'd0 || z_rv1 !== 32'd0)
            $display("FAIL midclear_rezeroed got a=%0d z=%0d exp=0", a_rv1, z_rv1); else passed++;
    endtask

    task automatic test_zero_reg();
        write1 = 1'b1; write_index1 = 5'd0; write_data1 = 32'hFFFFFFFF;
        read_index1 = 5'd0;
        tick();
        checks++; if (z_rv1 !== 32'd0 || a_rv1 !== e_a1)
            $display("FAIL zreg_same_cycle got z=%h a=%h exp z=0 a=%h", z_rv1, a_rv1, e_a1); else passed++;
        idle();
        tick();
        checks++; if (z_rv1 !== 32'd0 || a_rv1 !== 32'hFFFFFFFF)
            $display("FAIL zreg_read got z=%h a=%h exp z=0 a=ffffffff", z_rv1, a_rv1); else passed++;
        write1 = 1'b1; write_index1 = 5'd0; write_data1 = 32'd1;
        write2 = 1'b1; write_index2 = 5'd0; write_data2 = 32'd2;
        tick();
        checks++; if (z_col !== 1'b1 || a_col !== 1'b1)
            $display("FAIL zreg_collision got z=%b a=%b exp=1", z_col, a_col); else passed++;
        idle();
        tick();
        checks++; if (z_rv1 !== 32'd0 || a_rv1 !== 32'd1)
            $display("FAIL zreg_after_dual got z=%0d a=%0d exp z=0 a=1", z_rv1, a_rv1); else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            clear = ($urandom_range(0, 149) == 0);
            write1 = 1'($urandom_range(0, 1));
            write2 = 1'($urandom_range(0, 1));
            write_index1 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            write_index2 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            write_data1 = $urandom;
            write_data2 = $urandom;
            read_index1 = ($urandom_range(0, 2) == 0) ? write_index1 : 5'($urandom_range(0, 31));
            read_index2 = ($urandom_range(0, 2) == 0) ? write_index2 : 5'($urandom_range(0, 31));
            tick();
            checks++; if (a_rv1 !== e_a1 || a_rv2 !== e_a2)
                $display("FAIL rand_a_read n=%0d got %h %h exp %h %h", n, a_rv1, a_rv2, e_a1, e_a2); else passed++;
            checks++; if (z_rv1 !== e_z1 || z_rv2 !== e_z2)
                $display("FAIL rand_z_read n=%0d got %h %h exp %h %h", n, z_rv1, z_rv2, e_z1, e_z2); else passed++;
            checks++; if (a_ready !== e_ready || z_ready !== e_ready)
                $display("FAIL rand_ready n=%0d got %b %b exp %b", n, a_ready, z_ready, e_ready); else passed++;
            checks++; if (a_col !== e_col || z_col !== e_col)
                $display("FAIL rand_collision n=%0d got %b %b exp %b", n, a_col, z_col, e_col); else passed++;
        end
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_dual_write();
        test_collision();
        test_bypass();
        test_mid_clear();
        test_zero_reg();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
